// File: rtl/game_pkg.sv
// Shared encodings for the match sequencer: phases, round winners, tick rate.
package game_pkg;
    localparam int TICKS_PER_SEC = 20;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_PREP      = 3'd1,
        PH_COUNTDOWN = 3'd2,
        PH_FIGHT     = 3'd3,
        PH_ROUND_END = 3'd4,
        PH_MATCH_END = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;
endpackage

// File: rtl/match_second_timer.sv
// Loadable seconds down-counter driven by the game tick through a prescaler.
module match_second_timer
    import game_pkg::*;
#(
    parameter int         TICKS     = TICKS_PER_SEC,
    parameter logic [6:0] RESET_VAL = 7'd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       en,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [6:0] sec,
    output logic       zero,
    output logic       sec_strobe
);
    logic [4:0] presc;
    logic       wrap;

    assign wrap       = (presc == 5'(TICKS - 1));
    assign sec_strobe = tick && en && wrap;
    assign zero       = (sec == 7'd0);

    // A load restarts the prescaler so every phase gets full-length seconds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec   <= RESET_VAL;
            presc <= '0;
        end else if (load) begin
            sec   <= load_val;
            presc <= '0;
        end else if (tick && en) begin
            if (wrap) begin
                presc <= '0;
                if (sec != 7'd0)
                    sec <= sec - 7'd1;
            end else begin
                presc <= presc + 5'd1;
            end
        end
    end
endmodule

// File: rtl/match_flow_controller.sv
// Match sequencer: attract, round reset, countdown, timed fight, scoring, match end.
module match_flow_controller
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = game_pkg::TICKS_PER_SEC,
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 60,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int RESET_TICKS   = 2,
    parameter int RESULT_TICKS  = 40,
    parameter int HOLD_TICKS    = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       abort,
    input  logic [1:0] winner,
    input  logic [8:0] health_1,
    input  logic [8:0] health_2,
    output logic       round_reset,
    output logic       inputs_en,
    output logic [2:0] phase,
    output logic [3:0] countdown,
    output logic [6:0] round_time,
    output logic [3:0] round_num,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] match_winner
);
    phase_t     state, nxt;
    logic [5:0] cnt, cnt_nxt;
    logic [3:0] rn, rn_nxt;
    logic [1:0] p1, p1_nxt, p2, p2_nxt, mw, mw_nxt;
    winner_t    res;
    logic       ld, zero, strb;
    logic [6:0] ld_val, sec;

    match_second_timer #(
        .TICKS     (TICKS_PER_SEC),
        .RESET_VAL (7'(ROUND_SEC))
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .en         (state == PH_COUNTDOWN || state == PH_FIGHT),
        .load       (ld),
        .load_val   (ld_val),
        .sec        (sec),
        .zero       (zero),
        .sec_strobe (strb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PH_IDLE;
            cnt   <= '0;
            rn    <= 4'd1;
            p1    <= '0;
            p2    <= '0;
            mw    <= WIN_NONE;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            rn    <= rn_nxt;
            p1    <= p1_nxt;
            p2    <= p2_nxt;
            mw    <= mw_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        rn_nxt  = rn;
        p1_nxt  = p1;
        p2_nxt  = p2;
        mw_nxt  = mw;
        res     = WIN_NONE;
        if (tick) begin
            if (abort) begin
                nxt    = PH_IDLE;
                rn_nxt = 4'd1;
                p1_nxt = '0;
                p2_nxt = '0;
                mw_nxt = WIN_NONE;
            end else begin
                case (state)
                    PH_IDLE, PH_MATCH_END: begin
                        if (!start_btn)
                            cnt_nxt = '0;
                        else if (cnt == 6'(HOLD_TICKS - 1)) begin
                            nxt    = PH_PREP;
                            rn_nxt = 4'd1;
                            p1_nxt = '0;
                            p2_nxt = '0;
                            mw_nxt = WIN_NONE;
                        end else
                            cnt_nxt = cnt + 6'd1;
                    end
                    PH_PREP: begin
                        if (cnt == 6'(RESET_TICKS - 1))
                            nxt = PH_COUNTDOWN;
                        else
                            cnt_nxt = cnt + 6'd1;
                    end
                    PH_COUNTDOWN: begin
                        if (zero || (strb && sec == 7'd1))
                            nxt = PH_FIGHT;
                    end
                    PH_FIGHT: begin
                        if (winner_t'(winner) != WIN_NONE || zero) begin
                            nxt = PH_ROUND_END;
                            // A KO reported on the timeout tick outranks the health compare.
                            if (winner_t'(winner) != WIN_NONE)
                                res = winner_t'(winner);
                            else if (health_1 > health_2)
                                res = WIN_P1;
                            else if (health_2 > health_1)
                                res = WIN_P2;
                            else
                                res = WIN_DRAW;
                            if (res == WIN_P1 && p1 != 2'(ROUNDS_TO_WIN))
                                p1_nxt = p1 + 2'd1;
                            if (res == WIN_P2 && p2 != 2'(ROUNDS_TO_WIN))
                                p2_nxt = p2 + 2'd1;
                        end
                    end
                    PH_ROUND_END: begin
                        if (cnt == 6'(RESULT_TICKS - 1)) begin
                            if (p1 == 2'(ROUNDS_TO_WIN)) begin
                                mw_nxt = WIN_P1;
                                nxt    = PH_MATCH_END;
                            end else if (p2 == 2'(ROUNDS_TO_WIN)) begin
                                mw_nxt = WIN_P2;
                                nxt    = PH_MATCH_END;
                            end else begin
                                nxt = PH_PREP;
                                if (rn != 4'd15)
                                    rn_nxt = rn + 4'd1;
                            end
                        end else
                            cnt_nxt = cnt + 6'd1;
                    end
                    default: nxt = PH_IDLE;
                endcase
            end
        end
        // Every state entry restarts the tick counter and the seconds prescaler.
        ld = tick && (abort || nxt != state);
        if (ld)
            cnt_nxt = '0;
        case (nxt)
            PH_COUNTDOWN:                 ld_val = 7'(COUNTDOWN_SEC);
            PH_FIGHT, PH_IDLE, PH_PREP:   ld_val = 7'(ROUND_SEC);
            default:                      ld_val = sec;
        endcase
    end

    assign phase        = state;
    assign round_reset  = (state == PH_IDLE) || (state == PH_PREP);
    assign inputs_en    = (state == PH_FIGHT);
    assign countdown    = (state == PH_COUNTDOWN) ? sec[3:0] : 4'd0;
    assign round_time   = (state == PH_COUNTDOWN) ? 7'(ROUND_SEC) : sec;
    assign round_num    = rn;
    assign p1_rounds    = p1;
    assign p2_rounds    = p2;
    assign match_winner = mw;
endmodule
